// File: rtl/serial_frame_ctrl.sv
// Purpose: receive-side async serial frame capture (start 0, DATA_W data bits LSB first, stop 1).
// Latency: word valid 1 cycle after the stop-bit sample (fall + OVERSAMPLE*(DATA_W+1) + OVERSAMPLE/2 + 1).
// Backpressure: held word is frozen while data_ready=0; a newer completed frame is dropped with an overrun pulse.
//
// Ports:
//   clock, reset      - single clock, asynchronous active-low reset
//   Data_in           - raw serial line (idle high, asynchronous to clock)
//   rx_enable         - permits a new frame to start (looked at only while idle)
//   data_out/valid    - captured word and its valid flag
//   data_ready        - consumer accept
//   frame_err/overrun - single-cycle error pulses
//   busy              - receiver is inside a frame
module serial_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Data_in,
  input  logic              rx_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two-flop synchroniser plus registered falling-edge flag.
  logic sig_a_q, sig_b_q, fall_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_a_q <= 1'b1;
      sig_b_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sig_a_q <= Data_in;
      sig_b_q <= sig_a_q;
      fall_q  <= sig_b_q & ~sig_a_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Consumer handshake; a delivery below may re-set valid in the same cycle.
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fall_q && rx_enable) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          if (!sig_b_q) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
            idx_d   = '0;
          end else begin
            // Line back high at mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          // Right shift: the first received bit lands at the LSB.
          shift_d             = shift_q >> 1;
          shift_d[DATA_W-1]   = sig_b_q;
          cnt_d               = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (sig_b_q) begin
            // Accept coinciding with delivery frees the slot: no overrun, no valid gap.
            if (!valid_q || data_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
